// File: rtl/frame_parser.sv
// frame_parser: pulls bytes from a UART RX FIFO, hunts for SYNC_BYTE, checks
// the LEN field and the (LEN + payload) checksum, buffers the payload and
// replays it on a valid/ready stream once the frame checks out. Errors are
// reported as single-cycle pulses and counted in a saturating counter.
module frame_parser #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 27_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] in_data,
  input  logic       in_avail,
  output logic       in_pop,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       chk_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  localparam int unsigned    IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned    TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]     LEN_MAX8 = 8'(MAX_LEN);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_len;
  logic [7:0]      r_sum;
  logic [IW-1:0]   r_wr_idx;
  logic [IW-1:0]   r_rd_idx;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_buf [MAX_LEN];
  logic            r_frame_ok;
  logic            r_chk_err;
  logic            r_len_err;
  logic            r_tmo_err;
  logic [7:0]      r_err_count;

  logic            w_pop;
  logic            w_wait_state;
  logic            w_tmo_hit;
  logic [7:0]      w_len_m1;
  logic            w_len_bad;
  logic            w_wr_last;
  logic            w_rd_last;
  logic            w_xfer;
  logic            w_frame_ok;
  logic            w_chk_err;
  logic            w_len_err;
  logic            w_tmo_err;
  logic            w_any_err;

  // Datapath decodes shared by the FSM and the registers.
  always_comb begin
    w_wait_state = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // Gated by RST so the FIFO is never popped while reset is held.
    w_pop        = RST && in_avail && (w_wait_state || (r_state == S_HUNT));
    // A byte arriving on the expiry cycle wins over the timeout.
    w_tmo_hit    = w_wait_state && !w_pop && (r_tmo == TMO_LAST);
    w_len_m1     = r_len - 8'd1;
    w_len_bad    = (in_data == 8'd0) || (in_data > LEN_MAX8);
    w_wr_last    = (8'(r_wr_idx) == w_len_m1);
    w_rd_last    = (8'(r_rd_idx) == w_len_m1);
    w_xfer       = (r_state == S_DRAIN) && out_ready;
  end

  // Next-state and event decode.
  always_comb begin
    w_next     = r_state;
    w_frame_ok = 1'b0;
    w_chk_err  = 1'b0;
    w_len_err  = 1'b0;
    w_tmo_err  = 1'b0;
    unique case (r_state)
      S_HUNT: begin
        if (w_pop && (in_data == SYNC_BYTE)) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_pop) begin
          if (w_len_bad) begin
            w_len_err = 1'b1;
            w_next    = S_HUNT;
          end else begin
            w_next = S_PAYLOAD;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
          w_next    = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (w_pop) begin
          if (w_wr_last) w_next = S_CHK;
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
          w_next    = S_HUNT;
        end
      end
      S_CHK: begin
        if (w_pop) begin
          if (in_data == r_sum) begin
            w_frame_ok = 1'b1;
            w_next     = S_DRAIN;
          end else begin
            w_chk_err = 1'b1;
            w_next    = S_HUNT;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
          w_next    = S_HUNT;
        end
      end
      S_DRAIN: begin
        if (w_xfer && w_rd_last) w_next = S_HUNT;
      end
      default: w_next = S_HUNT;
    endcase
    w_any_err = w_chk_err || w_len_err || w_tmo_err;
  end

  // State register, frame bookkeeping, timeout counter and event pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_HUNT;
      r_len       <= '0;
      r_sum       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_tmo       <= '0;
      r_frame_ok  <= 1'b0;
      r_chk_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state    <= w_next;
      r_frame_ok <= w_frame_ok;
      r_chk_err  <= w_chk_err;
      r_len_err  <= w_len_err;
      r_tmo_err  <= w_tmo_err;

      if (w_any_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;

      if (w_pop || !w_wait_state || w_tmo_hit) r_tmo <= '0;
      else                                     r_tmo <= r_tmo + TW'(1);

      if ((r_state == S_LEN) && w_pop && !w_len_bad) begin
        r_len    <= in_data;
        r_sum    <= in_data;
        r_wr_idx <= '0;
      end

      if ((r_state == S_PAYLOAD) && w_pop) begin
        r_sum    <= r_sum + in_data;
        r_wr_idx <= r_wr_idx + IW'(1);
      end

      if (w_frame_ok) r_rd_idx <= '0;
      else if (w_xfer) r_rd_idx <= w_rd_last ? '0 : r_rd_idx + IW'(1);
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if ((r_state == S_PAYLOAD) && w_pop) r_buf[r_wr_idx] <= in_data;
  end

  assign in_pop      = w_pop;
  assign out_valid   = (r_state == S_DRAIN);
  assign out_data    = (r_state == S_DRAIN) ? r_buf[r_rd_idx] : '0;
  assign out_last    = (r_state == S_DRAIN) && w_rd_last;
  assign frame_ok    = r_frame_ok;
  assign chk_err     = r_chk_err;
  assign len_err     = r_len_err;
  assign timeout_err = r_tmo_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_frame_parser.sv
// Scoreboard bench for frame_parser: stimulus pushes expected output bytes
// and event codes into queues; a monitor pops and compares them.
module tb_frame_parser;

  localparam int unsigned TMO = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_avail = 1'b0;
  logic       in_pop;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok, chk_err, len_err, timeout_err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected outputs: {last, data}; events: 1 ok, 2 chk, 3 len, 4 timeout
  logic [8:0] exp_q [$];
  int         ev_q  [$];
  int         xfer_cyc [$];

  frame_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_avail(in_avail), .in_pop(in_pop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .chk_err(chk_err), .len_err(len_err), .timeout_err(timeout_err),
    .err_count(err_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endfunction

  // Offer one byte as the FIFO head until the DUT pops it.
  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    in_data  = b;
    in_avail = 1'b1;
    #1;
    while (!in_pop && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    if (!in_pop) fail("pop_wait", int'(b));
    @(negedge CLK);
    in_avail = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk({"drain_", nm}, exp_q.size() + ev_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Monitor: samples away from the rising edge.
  logic       hold_v = 1'b0;
  logic [8:0] hold_d = '0;
  initial begin
    int np;
    int code;
    forever begin
      @(negedge CLK); #2;
      if (!RST) begin
        hold_v = 1'b0;
        continue;
      end
      np = int'(frame_ok) + int'(chk_err) + int'(len_err) + int'(timeout_err);
      if (np != 0) begin
        code = frame_ok ? 1 : chk_err ? 2 : len_err ? 3 : 4;
        if (np > 1) chk("pulse_onehot", np, 1);
        if (ev_q.size() == 0) fail("unexpected_event", code);
        else chk("event", code, ev_q.pop_front());
      end
      if (hold_v) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'({out_last, out_data}), int'(hold_d));
      end
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail("unexpected_out", int'({out_last, out_data}));
        else chk("out_byte", int'({out_last, out_data}), int'(exp_q.pop_front()));
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_last, out_data};
    end
  end

  initial begin
    // reset state with a byte waiting in the FIFO
    in_avail = 1'b1;
    in_data  = 8'hA5;
    #12;
    chk("rst_in_pop", int'(in_pop), 0);
    chk("rst_out", int'({out_valid, out_last, out_data}), 0);
    chk("rst_pulses", int'({frame_ok, chk_err, len_err, timeout_err}), 0);
    chk("rst_errcnt", int'(err_count), 0);
    in_avail = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // good frame: checksum = 03+11+22+33 = 69
    xfer_cyc.delete();
    ev_q.push_back(1);
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    #1;
    chk("first_valid", int'({out_valid, frame_ok}), 3);
    chk("first_data", int'(out_data), 8'h11);
    wait_drain("good");
    if (xfer_cyc.size() == 3) begin
      chk("consec_1", xfer_cyc[1] - xfer_cyc[0], 1);
      chk("consec_2", xfer_cyc[2] - xfer_cyc[1], 1);
    end else fail("xfer_count", xfer_cyc.size());
    chk("errcnt_good", int'(err_count), 0);

    // MAX_LEN payload: 10 + (0+..+15) = 88
    ev_q.push_back(1);
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i == 15), 8'(i)});
      send(8'(i));
    end
    send(8'h88);
    wait_drain("maxlen");

    // bad checksum
    ev_q.push_back(2);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    wait_drain("chkerr");
    chk("errcnt_chk", int'(err_count), 1);

    // sync as length, noise, zero length, oversize length, then a good frame
    ev_q.push_back(3); ev_q.push_back(3); ev_q.push_back(3); ev_q.push_back(1);
    exp_q.push_back(9'h17E);
    send(8'hA5); send(8'hA5);
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
    send(8'hA5); send(8'h11);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_drain("lenerr");
    chk("errcnt_len", int'(err_count), 4);

    // bytes arriving exactly on the expiry cycle win
    ev_q.push_back(1);
    exp_q.push_back(9'h17E);
    send(8'hA5); repeat (TMO - 1) @(negedge CLK);
    send(8'h01); repeat (TMO - 1) @(negedge CLK);
    send(8'h7E); repeat (TMO - 1) @(negedge CLK);
    send(8'h7F);
    wait_drain("tmo_win");
    chk("errcnt_win", int'(err_count), 4);

    // real timeout
    ev_q.push_back(4);
    send(8'hA5); send(8'h02); send(8'h01);
    repeat (TMO - 1) @(negedge CLK);
    #1;
    chk("tmo_early", int'(timeout_err), 0);
    @(negedge CLK); #1;
    chk("tmo_fire", int'(timeout_err), 1);
    wait_drain("tmo");
    chk("errcnt_tmo", int'(err_count), 5);
    ev_q.push_back(1);
    exp_q.push_back(9'h155);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    wait_drain("after_tmo");

    // backpressure: 04+10+20+30+40 = A4
    out_ready = 1'b0;
    ev_q.push_back(1);
    exp_q.push_back(9'h010); exp_q.push_back(9'h020);
    exp_q.push_back(9'h030); exp_q.push_back(9'h140);
    send(8'hA5); send(8'h04); send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'hA4);
    in_data  = 8'hA5;
    in_avail = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_pop", int'(in_pop), 0);
      chk("bp_hold", int'({out_valid, out_data}), 9'h110);
      @(negedge CLK);
    end
    in_avail  = 1'b0;
    out_ready = 1'b1;
    wait_drain("bp");
    chk("errcnt_bp", int'(err_count), 5);

    // reset during drain after one byte: 03+01+02+03 = 09
    out_ready = 1'b0;
    ev_q.push_back(1);
    exp_q.push_back(9'h001);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h09);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    RST = 1'b0;
    #1;
    chk("rst_drain_out", int'({out_valid, out_last, out_data}), 0);
    chk("rst_drain_err", int'(err_count), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    out_ready = 1'b1;
    chk("rst_drain_q", exp_q.size() + ev_q.size(), 0);
    ev_q.push_back(1);
    exp_q.push_back(9'h17E);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_drain("after_rst");

    // error counter saturation
    do_reset();
    for (int i = 0; i < 255; i++) begin
      ev_q.push_back(3);
      send(8'hA5); send(8'h00);
    end
    chk("errcnt_255", int'(err_count), 255);
    ev_q.push_back(3);
    send(8'hA5); send(8'h00);
    chk("errcnt_sat", int'(err_count), 255);
    wait_drain("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1, "bench time limit");
  end

endmodule
